zbus_cycle_decoder: RTL and testbench

- Consumes the asynchronous Z80 bus strobes (iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n) and address, as driven by the CPU (or the delayed CPU model in simulation).
- Synchronises them into the fclk domain and glitch-filters them.
- Classifies each bus cycle with a state machine and emits single-fclk strobes plus a captured address to the downstream memory/port arbiters.
- Sits directly behind the top-level Z80 pins, ahead of the DRAM/ROM/port decoders.

---
 rtl/zbus_cycle_decoder.sv | 198 +++++++++++++++++++
 tb/tb_zbus_cycle_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zbus_cycle_decoder.sv
// Z80 bus cycle decoder: synchronises and glitch-filters the async bus strobes,
// classifies each bus cycle and emits single-fclk start/end strobes plus the cycle address.
module zbus_cycle_decoder #(
  parameter int unsigned FILT = 2
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        iorq_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  input  logic [15:0] a,
  output logic        memrd_stb,
  output logic        memwr_stb,
  output logic        m1_stb,
  output logic        rfsh_stb,
  output logic        iord_stb,
  output logic        iowr_stb,
  output logic        intack_stb,
  output logic        end_stb,
  output logic [15:0] cyc_addr,
  output logic [2:0]  cyc_type,
  output logic        busy,
  output logic        conflict
);

  localparam int unsigned NCTL   = 6;
  localparam int unsigned I_IORQ = 0;
  localparam int unsigned I_MREQ = 1;
  localparam int unsigned I_RD   = 2;
  localparam int unsigned I_WR   = 3;
  localparam int unsigned I_M1   = 4;
  localparam int unsigned I_RFSH = 5;
  localparam logic [2:0]  FILT_MAX = 3'(FILT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEMWAIT = 3'd1,
    S_MEMRD   = 3'd2,
    S_MEMWR   = 3'd3,
    S_RFSH    = 3'd4,
    S_IOWAIT  = 3'd5,
    S_IORW    = 3'd6,
    S_INTACK  = 3'd7
  } state_t;

  typedef struct packed {
    logic memrd;
    logic memwr;
    logic m1;
    logic rfsh;
    logic iord;
    logic iowr;
    logic intack;
    logic cyc_end;
  } stb_t;

  logic [NCTL-1:0] ctl_raw, ctl_s1, ctl_s2, ctl_f, ctl_fn;
  logic [15:0]     a_s1, a_s2;
  logic [2:0]      cnt [NCTL];
  logic [1:0]      sync_vld;

  state_t state_q, state_d;
  stb_t   stb_q, stb_d;
  logic   hold_q, hold_d;
  logic   conflict_q, conflict_d;
  logic   capture, released;
  logic   mreq, iorq, rd, wr, m1, rfsh;

  assign ctl_raw = {rfsh_n, m1_n, wr_n, rd_n, mreq_n, iorq_n};

  always_ff @(posedge fclk) begin
    if (rst) begin
      ctl_s1   <= '1;
      ctl_s2   <= '1;
      a_s1     <= '0;
      a_s2     <= '0;
      sync_vld <= '0;
    end else begin
      ctl_s1   <= ctl_raw;
      ctl_s2   <= ctl_s1;
      a_s1     <= a;
      a_s2     <= a_s1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Filtered value flips on the edge where the line has differed for FILT cycles.
  always_comb begin
    ctl_fn = ctl_f;
    for (int unsigned i = 0; i < NCTL; i++) begin
      if (ctl_s2[i] != ctl_f[i] && cnt[i] == FILT_MAX) ctl_fn[i] = ctl_s2[i];
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      ctl_f <= '1;
      for (int unsigned i = 0; i < NCTL; i++) cnt[i] <= '0;
    end else begin
      ctl_f <= ctl_fn;
      for (int unsigned i = 0; i < NCTL; i++) begin
        if (ctl_s2[i] == ctl_f[i] || cnt[i] == FILT_MAX) cnt[i] <= '0;
        else                                             cnt[i] <= cnt[i] + 3'd1;
      end
    end
  end

  // Decode on the next filtered values so strobes leave a register at 2+FILT latency.
  assign mreq = ~ctl_fn[I_MREQ];
  assign iorq = ~ctl_fn[I_IORQ];
  assign rd   = ~ctl_fn[I_RD];
  assign wr   = ~ctl_fn[I_WR];
  assign m1   = ~ctl_fn[I_M1];
  assign rfsh = ~ctl_fn[I_RFSH];

  // hold blocks new starts after reset/conflict until both requests are seen released end to end.
  assign released = sync_vld[1] & ctl_s2[I_MREQ] & ctl_s2[I_IORQ]
                  & ctl_fn[I_MREQ] & ctl_fn[I_IORQ];

  always_comb begin
    state_d    = state_q;
    stb_d      = '0;
    hold_d     = hold_q;
    conflict_d = conflict_q;
    unique case (state_q)
      S_IDLE: begin
        if (hold_q) begin
          if (released) hold_d = 1'b0;
        end else if (mreq && iorq) begin
          conflict_d = 1'b1;
          hold_d     = 1'b1;
        end else if (mreq) begin
          if (rfsh)    begin state_d = S_RFSH;  stb_d.rfsh  = 1'b1; end
          else if (m1) begin state_d = S_MEMRD; stb_d.m1    = 1'b1; end
          else if (rd) begin state_d = S_MEMRD; stb_d.memrd = 1'b1; end
          else if (wr) begin state_d = S_MEMWR; stb_d.memwr = 1'b1; end
          else               state_d = S_MEMWAIT;
        end else if (iorq) begin
          if (m1)      begin state_d = S_INTACK; stb_d.intack = 1'b1; end
          else if (rd) begin state_d = S_IORW;   stb_d.iord   = 1'b1; end
          else if (wr) begin state_d = S_IORW;   stb_d.iowr   = 1'b1; end
          else               state_d = S_IOWAIT;
        end
      end
      S_MEMWAIT: begin
        if (!mreq)   begin state_d = S_IDLE;  stb_d.cyc_end = 1'b1; end
        else if (rd) begin state_d = S_MEMRD; stb_d.memrd   = 1'b1; end
        else if (wr) begin state_d = S_MEMWR; stb_d.memwr   = 1'b1; end
      end
      S_IOWAIT: begin
        if (!iorq)   begin state_d = S_IDLE; stb_d.cyc_end = 1'b1; end
        else if (rd) begin state_d = S_IORW; stb_d.iord    = 1'b1; end
        else if (wr) begin state_d = S_IORW; stb_d.iowr    = 1'b1; end
      end
      S_MEMRD, S_MEMWR, S_RFSH: begin
        if (!mreq) begin state_d = S_IDLE; stb_d.cyc_end = 1'b1; end
      end
      S_IORW, S_INTACK: begin
        if (!iorq) begin state_d = S_IDLE; stb_d.cyc_end = 1'b1; end
      end
      default: state_d = S_IDLE;
    endcase
    capture = stb_d.memrd | stb_d.memwr | stb_d.m1 | stb_d.rfsh
            | stb_d.iord | stb_d.iowr | stb_d.intack;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stb_q      <= '0;
      hold_q     <= 1'b1;
      conflict_q <= 1'b0;
      cyc_addr   <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      hold_q     <= hold_d;
      conflict_q <= conflict_d;
      if (capture) cyc_addr <= a_s2;
    end
  end

  assign memrd_stb  = stb_q.memrd;
  assign memwr_stb  = stb_q.memwr;
  assign m1_stb     = stb_q.m1;
  assign rfsh_stb   = stb_q.rfsh;
  assign iord_stb   = stb_q.iord;
  assign iowr_stb   = stb_q.iowr;
  assign intack_stb = stb_q.intack;
  assign end_stb    = stb_q.cyc_end;
  assign cyc_type   = state_q;
  assign busy       = (state_q != S_IDLE);
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_zbus_cycle_decoder.sv
// Directed bench for zbus_cycle_decoder: table of single-cycle decodes plus
// hand sequences for delayed write, glitch rejection, conflict and mid-cycle reset.
module tb_zbus_cycle_decoder;

  logic        fclk = 1'b0;
  logic        rst;
  logic        iorq_n, mreq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [15:0] a;

  logic        memrd_stb, memwr_stb, m1_stb, rfsh_stb, iord_stb, iowr_stb, intack_stb, end_stb;
  logic [15:0] cyc_addr;
  logic [2:0]  cyc_type;
  logic        busy, conflict;

  logic        memrd_stb3, memwr_stb3, m1_stb3, rfsh_stb3, iord_stb3, iowr_stb3, intack_stb3, end_stb3;
  logic [15:0] cyc_addr3;
  logic [2:0]  cyc_type3;
  logic        busy3, conflict3;

  int errors = 0;
  int checks = 0;

  always #5 fclk = ~fclk;

  zbus_cycle_decoder #(.FILT(2)) dut (
    .fclk(fclk), .rst(rst), .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .a(a),
    .memrd_stb(memrd_stb), .memwr_stb(memwr_stb), .m1_stb(m1_stb), .rfsh_stb(rfsh_stb),
    .iord_stb(iord_stb), .iowr_stb(iowr_stb), .intack_stb(intack_stb), .end_stb(end_stb),
    .cyc_addr(cyc_addr), .cyc_type(cyc_type), .busy(busy), .conflict(conflict)
  );

  zbus_cycle_decoder #(.FILT(3)) dut3 (
    .fclk(fclk), .rst(rst), .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .a(a),
    .memrd_stb(memrd_stb3), .memwr_stb(memwr_stb3), .m1_stb(m1_stb3), .rfsh_stb(rfsh_stb3),
    .iord_stb(iord_stb3), .iowr_stb(iowr_stb3), .intack_stb(intack_stb3), .end_stb(end_stb3),
    .cyc_addr(cyc_addr3), .cyc_type(cyc_type3), .busy(busy3), .conflict(conflict3)
  );

  // ctl is {rfsh_n, m1_n, wr_n, rd_n, mreq_n, iorq_n}; stb is {memrd, memwr, m1, rfsh, iord, iowr, intack}
  typedef struct {
    string       name;
    logic [5:0]  ctl;
    logic [15:0] addr_in;
    logic [6:0]  stb;
    logic [2:0]  typ;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [6:0] stbv();
    return {memrd_stb, memwr_stb, m1_stb, rfsh_stb, iord_stb, iowr_stb, intack_stb};
  endfunction

  function automatic logic [6:0] stbv3();
    return {memrd_stb3, memwr_stb3, m1_stb3, rfsh_stb3, iord_stb3, iowr_stb3, intack_stb3};
  endfunction

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [15:0] addr);
    {rfsh_n, m1_n, wr_n, rd_n, mreq_n, iorq_n} = ctl;
    a = addr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic flag;

    vecs[0]  = '{"fetch",     6'b101001, 16'h0038, 7'b0010000, 3'd2, 16'h0038};
    vecs[1]  = '{"memrd",     6'b111001, 16'h1234, 7'b1000000, 3'd2, 16'h1234};
    vecs[2]  = '{"memwr",     6'b110101, 16'h5B00, 7'b0100000, 3'd3, 16'h5B00};
    vecs[3]  = '{"rfsh",      6'b011101, 16'h007F, 7'b0001000, 3'd4, 16'h007F};
    vecs[4]  = '{"iord",      6'b111010, 16'h00FE, 7'b0000100, 3'd6, 16'h00FE};
    vecs[5]  = '{"iowr",      6'b110110, 16'h00FE, 7'b0000010, 3'd6, 16'h00FE};
    vecs[6]  = '{"intack",    6'b101110, 16'h00FF, 7'b0000001, 3'd7, 16'h00FF};
    vecs[7]  = '{"rd_wins",   6'b110001, 16'h4000, 7'b1000000, 3'd2, 16'h4000};
    vecs[8]  = '{"memwait",   6'b111101, 16'h9999, 7'b0000000, 3'd1, 16'h4000};
    vecs[9]  = '{"iowait",    6'b111110, 16'h8888, 7'b0000000, 3'd5, 16'h4000};
    vecs[10] = '{"rfsh_m1",   6'b001101, 16'h0011, 7'b0001000, 3'd4, 16'h0011};

    rst = 1'b1;
    drive(6'b111111, 16'h0000);
    steps(3);
    chk("reset_stb",      32'(stbv()),   32'h0);
    chk("reset_end",      32'(end_stb),  32'h0);
    chk("reset_addr",     32'(cyc_addr), 32'h0);
    chk("reset_type",     32'(cyc_type), 32'h0);
    chk("reset_busy",     32'(busy),     32'h0);
    chk("reset_conflict", 32'(conflict), 32'h0);
    rst = 1'b0;
    steps(5);

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].ctl, vecs[v].addr_in);
      steps(3);
      chk($sformatf("%s_c3_stb", vecs[v].name), 32'(stbv()), 32'h0);
      step();
      chk($sformatf("%s_c4_stb", vecs[v].name),  32'(stbv()),   32'(vecs[v].stb));
      chk($sformatf("%s_c4_type", vecs[v].name), 32'(cyc_type), 32'(vecs[v].typ));
      chk($sformatf("%s_c4_addr", vecs[v].name), 32'(cyc_addr), 32'(vecs[v].addr));
      chk($sformatf("%s_c4_busy", vecs[v].name), 32'(busy),     32'h1);
      step();
      chk($sformatf("%s_c5_stb", vecs[v].name), 32'(stbv()), 32'h0);
      drive(6'b111111, vecs[v].addr_in);
      steps(3);
      chk($sformatf("%s_rel_c3_end", vecs[v].name), 32'(end_stb), 32'h0);
      step();
      chk($sformatf("%s_rel_c4_end", vecs[v].name),  32'(end_stb),  32'h1);
      chk($sformatf("%s_rel_c4_type", vecs[v].name), 32'(cyc_type), 32'h0);
      step();
      chk($sformatf("%s_rel_c5_end", vecs[v].name), 32'(end_stb), 32'h0);
      steps(2);
    end

    // Delayed memory write: MREQ first, WR six cycles later
    flag = 1'b0;
    drive(6'b111101, 16'h5B00);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (memrd_stb) flag = 1'b1;
      if (c == 3)  chk("dwr_c3_type", 32'(cyc_type), 32'h0);
      if (c == 4) begin
        chk("dwr_c4_type", 32'(cyc_type), 32'h1);
        chk("dwr_c4_stb",  32'(stbv()),   32'h0);
      end
      if (c == 6)  drive(6'b110101, 16'h5B00);
      if (c == 9)  chk("dwr_c9_stb", 32'(stbv()), 32'h0);
      if (c == 10) begin
        chk("dwr_c10_stb",  32'(stbv()),   32'(7'b0100000));
        chk("dwr_c10_addr", 32'(cyc_addr), 32'h5B00);
        chk("dwr_c10_type", 32'(cyc_type), 32'h3);
      end
    end
    chk("dwr_no_memrd", 32'(flag), 32'h0);
    drive(6'b111111, 16'h5B00);
    steps(8);

    // Glitch rejection on the FILT=3 instance
    flag = 1'b0;
    drive(6'b111101, 16'h1111);
    steps(2);
    drive(6'b111111, 16'h1111);
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy3 || stbv3() != 7'h0 || end_stb3) flag = 1'b1;
    end
    chk("glitch3_quiet", 32'(flag), 32'h0);
    drive(6'b111101, 16'h1111);
    steps(4);
    chk("hold3_c4_busy", 32'(busy3), 32'h0);
    step();
    chk("hold3_c5_busy", 32'(busy3),     32'h1);
    chk("hold3_c5_type", 32'(cyc_type3), 32'h1);
    drive(6'b111111, 16'h1111);
    steps(10);

    // MREQ and IORQ together
    drive(6'b111100, 16'h2222);
    steps(3);
    chk("conf_c3", 32'(conflict), 32'h0);
    step();
    chk("conf_c4",      32'(conflict), 32'h1);
    chk("conf_c4_stb",  32'(stbv()),   32'h0);
    chk("conf_c4_busy", 32'(busy),     32'h0);
    drive(6'b111111, 16'h2222);
    steps(10);
    chk("conf_sticky", 32'(conflict), 32'h1);
    chk("conf_idle",   32'(busy),     32'h0);
    drive(6'b111001, 16'h2222);
    steps(4);
    chk("conf_after_stb",  32'(stbv()),   32'(7'b1000000));
    chk("conf_after_addr", 32'(cyc_addr), 32'h2222);
    drive(6'b111111, 16'h2222);
    steps(8);
    rst = 1'b1;
    step();
    chk("conf_rst_clear", 32'(conflict), 32'h0);
    rst = 1'b0;
    steps(5);

    // Reset during MEMRD
    drive(6'b101001, 16'h0038);
    steps(5);
    chk("mrst_in_memrd", 32'(cyc_type), 32'h2);
    rst = 1'b1;
    step();
    chk("mrst_stb",  32'({stbv(), end_stb}), 32'h0);
    chk("mrst_addr", 32'(cyc_addr),          32'h0);
    chk("mrst_type", 32'(cyc_type),          32'h0);
    chk("mrst_busy", 32'(busy),              32'h0);
    rst = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy || stbv() != 7'h0) flag = 1'b1;
    end
    chk("mrst_ignored", 32'(flag), 32'h0);
    drive(6'b111111, 16'h0038);
    flag = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy || end_stb) flag = 1'b1;
    end
    chk("mrst_no_end", 32'(flag), 32'h0);
    drive(6'b101001, 16'h0100);
    steps(4);
    chk("mrst_new_stb",  32'(stbv()),   32'(7'b0010000));
    chk("mrst_new_addr", 32'(cyc_addr), 32'h0100);
    chk("mrst_new_type", 32'(cyc_type), 32'h2);
    drive(6'b111111, 16'h0100);
    steps(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
